// File: rtl/ptw_mem_responder_if.sv
// ptw_mem_responder_if: AXI-Lite read channel between the MMU page-table
// walker (master) and the page-table memory responder (slave).
//   araddr/arvalid/arready : read address channel
//   rvalid/rready/rdata/rresp : read response channel
interface ptw_mem_responder_if;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  modport master (output araddr, arvalid, rready,
                  input  arready, rvalid, rdata, rresp);
  modport slave  (input  araddr, arvalid, rready,
                  output arready, rvalid, rdata, rresp);
endinterface

// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder: AXI-Lite read responder serving page-table-walk reads.
// Holds PTEs in a word array loaded through a simple preload port, accepts up
// to two outstanding reads, and returns each after a fixed latency, in order.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : read address / read response channel (slave side)
//   init_we     : preload write enable
//   init_addr   : preload word index
//   init_wdata  : preload data
module ptw_mem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  ptw_mem_responder_if.slave    bus,
  input  logic                  init_we,
  input  logic [AW-1:0]         init_addr,
  input  logic [63:0]           init_wdata
);

  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [63:0] DEPTH64  = 64'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic          err;
  } q_ent_t;

  logic [63:0] mem [DEPTH_WORDS];

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  q_ent_t      q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic        push, pop, load;
  logic [63:0] off, idx_full;
  logic        ar_err;
  q_ent_t      head;

  // Decode in full 64-bit width so below-base addresses never wrap into range.
  assign off      = bus.araddr - BASE_ADDR;
  assign idx_full = off >> 3;
  assign ar_err   = (bus.araddr[2:0] != 3'd0) || (bus.araddr < BASE_ADDR) ||
                    (idx_full >= DEPTH64);

  // Based on count before any same-cycle pop: a full queue never accepts.
  assign bus.arready = (count < 2'd2) && !rst;
  assign push        = bus.arvalid && bus.arready;
  assign head        = q[rd_ptr];

  // IDLE also reacts to a push in the same cycle so the first response lands
  // exactly LATENCY edges after the AR handshake (LATENCY=1 included).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0 || push) begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          load      = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rready) begin
          pop = 1'b1;
          // Head leaves; anything else (already queued or arriving now) follows.
          if (count == 2'd2 || push) begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      q[0]       <= '0;
      q[1]       <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= 2'b00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (push) begin
        q[wr_ptr] <= '{idx: idx_full[AW-1:0], err: ar_err};
        wr_ptr    <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (load) begin
        bus.rvalid <= 1'b1;
        bus.rresp  <= head.err ? 2'b10 : 2'b00;
        bus.rdata  <= head.err ? 64'h0 : mem[head.idx];
      end else if (pop) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  // Memory contents survive reset; a same-edge preload is seen by later reads only.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_wdata;
  end

endmodule

// File: doc/ptw_mem_responder.md
Name: ptw_mem_responder

Overview:
AXI-Lite read-channel responder that serves page-table-walk reads from the MMU. It holds page-table memory in a word array that the bench or boot logic preloads through a simple write port. It accepts up to two outstanding read addresses, applies a fixed access latency, and returns 64-bit PTE data with OKAY or SLVERR responses. It sits on the MMU's araddr/arvalid/arready/rvalid/rready/rdata/rresp interface, as the other end of that handshake.

Parameters:
BASE_ADDR, 64'h0000_0000_8000_0000, byte address mapped to word 0 of the array
DEPTH_WORDS, 4096, number of 64-bit words in the array (power of two)
LATENCY, 2, cycles from AR handshake to rvalid when the queue is empty (legal range 1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
araddr  input  64  read byte address
arvalid  input  1  read address valid
arready  output  1  responder can accept an address
rvalid  output  1  read response valid
rready  input  1  initiator accepts the response
rdata  output  64  read data (PTE)
rresp  output  2  2'b00 OKAY, 2'b10 SLVERR
init_we  input  1  preload write enable
init_addr  input  $clog2(DEPTH_WORDS)  preload word index
init_wdata  input  64  preload data

Behaviour:
- Reset values: arready=0 while rst is high; rvalid=0; rdata=0; rresp=2'b00. The queue empties and the FSM enters IDLE. Memory contents are NOT reset.
- Reset mid-operation: rvalid drops asynchronously and pending reads are discarded. arready=1 from the first edge after rst deasserts.
- arready = (queue count < 2) && !rst. It is a function of the count before any same-cycle pop: a full queue never accepts, even while popping.
- AR handshake (arvalid && arready at an edge): push {idx, err}, where idx = (araddr - BASE_ADDR) >> 3.
- err = 1 if araddr[2:0] != 0, araddr < BASE_ADDR, or idx >= DEPTH_WORDS. Compute err with full 64-bit arithmetic; there is no wrap.
- Queue: 2-entry FIFO with wrap-around read and write pointers and a 2-bit count. The count updates on push and pop in the same cycle.
- FSM IDLE: if the queue is non-empty, load the latency counter and go to WAIT.
- FSM WAIT: decrement the counter. At expiry, register rdata/rresp from the head entry, set rvalid, and go to RESP.
- FSM RESP: hold rvalid, rdata and rresp stable until rready. On the rvalid && rready edge: pop the head and clear rvalid.
  - If another entry is queued, go to WAIT with the counter reloaded.
  - Otherwise go to IDLE.
- Timing: an AR accepted at edge t into an empty, idle block raises rvalid at edge t+LATENCY. A queued second request raises rvalid LATENCY edges after the first response's handshake.
- Error response: rresp=2'b10, rdata=64'h0, and the array is not read.
- OKAY response: rresp=2'b00, rdata = mem[idx] sampled at the edge that raises rvalid.
- Preload: init_we writes mem[init_addr] = init_wdata at the edge. There is no bounds wrap (init_addr width fits DEPTH_WORDS exactly).
  - A preload to the same word at the edge that samples rdata returns the OLD value.
  - A later preload never alters a held rdata.
- rready while rvalid=0 is ignored. arvalid may stay high across cycles; each high-arvalid edge with arready=1 is a distinct request.
- No write channel. There is no reordering: responses are returned strictly in AR order.

Test Plan:
- Preload mem[0]=64'h0000_0000_2000_0401; AR araddr=0x8000_0000 with rready=1 -> rvalid at edge t+2, rdata=64'h0000_0000_2000_0401, rresp=00, arready stays 1.
- Misaligned araddr=0x8000_0004, then below-base araddr=0x7FFF_FFF8, then araddr=0x8000_8000 (idx=4096) -> three responses in order, each rresp=10, rdata=0.
- Back-to-back AR 0x8000_0008 and 0x8000_0010 with rready=0 -> arready=0 after the second push, a third AR is not accepted, rdata stays mem[1] until rready=1. Then mem[2] follows LATENCY edges after that handshake, in order.
- Preload mem[3]=A, AR 0x8000_0018, and write mem[3]=B at the rvalid-raising edge -> rdata=A, held stable. A later read of word 3 returns B.
- Assert rst for one cycle mid-WAIT with one entry queued -> rvalid=0 immediately, arready=0 during rst then 1. No stale response appears. Preloaded data is still readable afterwards.
- LATENCY=1 build: AR at edge t -> rvalid at t+1. A continuous stream with rready=1 returns one response per 2 cycles with no lost or duplicated beats.
